// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble (shift-and-add-3) binary-to-BCD converter.
// One conversion per start request, N_BITS shift cycles, then a one-cycle
// done pulse with the new digits on bcd. bcd holds between conversions.
// Optional feature macro: BCD_LZ_BLANK_EN (registered leading-zero blank
// flags on the blank port; when undefined blank is tied to zero).
module bin_to_bcd_seq #(
  parameter int N_BITS   = 8,
  parameter int N_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_BITS-1:0]       binary,
  output logic                    busy,
  output logic                    done,
  output logic [4*N_DIGITS-1:0]   bcd,
  output logic [N_DIGITS-1:0]     blank
);

  localparam int CW = $clog2(N_BITS + 1);
  localparam int SW = 4 * N_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [N_BITS-1:0] shift_reg, shift_next;
  logic [SW-1:0]   scratch_reg, scratch_next;
  logic [SW-1:0]   adj;
  logic [CW-1:0]   count_reg, count_next;
  logic [SW-1:0]   bcd_reg, bcd_next;
  logic            bcd_load;

  // Add-3 correction on every scratch digit in parallel, before the shift.
  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                              ? scratch_reg[4*gi +: 4] + 4'd3
                              : scratch_reg[4*gi +: 4];
    end
  endgenerate

  // Next-state, datapath and result-load logic.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    scratch_next = scratch_reg;
    count_next   = count_reg;
    bcd_next     = bcd_reg;
    bcd_load     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          shift_next   = binary;
          scratch_next = '0;
          count_next   = CW'(N_BITS);
          state_next   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {scratch_next, shift_next} = {adj[SW-2:0], shift_reg, 1'b0};
        count_next = count_reg - 1'b1;
        if (count_reg == CW'(1)) begin
          // Last shift: publish the complete result in one step.
          bcd_load   = 1'b1;
          bcd_next   = {adj[SW-2:0], shift_reg[N_BITS-1]};
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      shift_reg   <= '0;
      scratch_reg <= '0;
      count_reg   <= '0;
      bcd_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      scratch_reg <= scratch_next;
      count_reg   <= count_next;
      bcd_reg     <= bcd_next;
    end
  end

  assign busy = (state_reg == S_SHIFT);
  assign done = (state_reg == S_DONE);
  assign bcd  = bcd_reg;

`ifdef BCD_LZ_BLANK_EN
  logic [N_DIGITS-1:0] blank_reg, blank_next;

  // Digit i is blanked when it and every digit above it are zero.
  assign blank_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < N_DIGITS; gi++) begin : g_blank
      assign blank_next[gi] = (bcd_next[SW-1:4*gi] == '0);
    end
  endgenerate

  // Blank flags change in the same cycle as bcd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_reg <= '0;
    end else if (bcd_load) begin
      blank_reg <= blank_next;
    end
  end

  assign blank = blank_reg;
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (N_BITS=8, N_DIGITS=3).
// Expected digits come from decimal arithmetic on the input value.
module tb_bin_to_bcd_seq;

  localparam int NB = 8;
  localparam int ND = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [NB-1:0]   binary;
  logic            busy;
  logic            done;
  logic [4*ND-1:0] bcd;
  logic [ND-1:0]   blank;

  int n_cmp = 0;
  int n_err = 0;

  bin_to_bcd_seq #(.N_BITS(NB), .N_DIGITS(ND)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .binary (binary),
    .busy   (busy),
    .done   (done),
    .bcd    (bcd),
    .blank  (blank)
  );

  always #5 clk = ~clk;

  function automatic logic [4*ND-1:0] ref_bcd(input int v);
    logic [4*ND-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [ND-1:0] ref_blank(input int v);
    logic [ND-1:0] r;
    int p;
    r = '0;
`ifdef BCD_LZ_BLANK_EN
    p = 10;
    for (int i = 1; i < ND; i++) begin
      r[i] = (v < p);
      p = p * 10;
    end
`else
    p = 0;
    if (p != 0) r = '1;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge in IDLE, ends at the negedge of the following IDLE cycle.
  task automatic conv(input int v, input bit keep_start);
    start  = 1'b1;
    binary = NB'(v);
    @(posedge clk);
    #1;
    if (!keep_start) start = 1'b0;
    for (int c = 0; c < NB; c++) begin
      @(negedge clk);
      check("busy_during_shift", 32'(busy), 32'd1);
      check("no_done_during_shift", 32'(done), 32'd0);
    end
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("busy_low_at_done", 32'(busy), 32'd0);
    check("bcd_value", 32'(bcd), 32'(ref_bcd(v)));
    check("blank_value", 32'(blank), 32'(ref_blank(v)));
    @(negedge clk);
    check("done_single_cycle", 32'(done), 32'd0);
    check("bcd_held", 32'(bcd), 32'(ref_bcd(v)));
    $display("conv v=%0d bcd=%03h blank=%b", v, bcd, blank);
  endtask

  initial begin
    int v;
    rst    = 1'b1;
    start  = 1'b0;
    binary = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_bcd", 32'(bcd), 32'd0);
    check("reset_blank", 32'(blank), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed values from the test plan.
    conv(255, 1'b0);
    conv(0, 1'b0);
    conv(100, 1'b0);
    conv(7, 1'b0);

    // A second start during SHIFT must be ignored.
    start  = 1'b1;
    binary = NB'(37);
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= NB; c++) begin
      @(negedge clk);
      check("busy_ignored_start", 32'(busy), 32'd1);
      if (c == 3) begin
        start  = 1'b1;
        binary = NB'(200);
      end
      if (c == 4) start = 1'b0;
    end
    @(negedge clk);
    check("done_ignored_start", 32'(done), 32'd1);
    check("bcd_ignored_start", 32'(bcd), 32'(ref_bcd(37)));
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("no_second_done", 32'(done), 32'd0);
      check("no_second_busy", 32'(busy), 32'd0);
    end
    check("bcd_kept_37", 32'(bcd), 32'(ref_bcd(37)));
    $display("ignored-start case bcd=%03h", bcd);

    // Reset in the middle of a conversion.
    start  = 1'b1;
    binary = NB'(99);
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("busy_before_abort", 32'(busy), 32'd1);
    end
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    check("abort_blank", 32'(blank), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("no_done_after_abort", 32'(done), 32'd0);
      check("idle_after_abort", 32'(busy), 32'd0);
    end
    $display("reset-abort case bcd=%03h", bcd);
    conv(42, 1'b0);

    // Random values.
    for (int k = 0; k < 24; k++) begin
      v = int'($urandom_range(0, 255));
      conv(v, 1'b0);
    end

    // Exhaustive sweep with start held high: back-to-back every NB+2 cycles.
    for (int k = 0; k < 256; k++) begin
      conv(k, 1'b1);
    end
    start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #400000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
